// File: rtl/scan_integrator.sv
// -----------------------------------------------------------------------------
// scan_integrator
//
// Steps the transducer-array mux through every element in raster order. After
// each mux change it discards SETTLE_WINDOWS sampler windows. It then integrates
// sel_count*center_count over ACCUM_WINDOWS windows and presents one scaled,
// saturated 16-bit result per element on a valid/ready output.
//
// Ports:
//   clk           single clock
//   rst           synchronous, active-high reset
//   enable        scan run request (sampled in IDLE and at the handshake)
//   count_valid   one-cycle strobe: new sel_count/center_count window pair
//   sel_count     selected-element sampler count
//   center_count  center-element sampler count
//   row, col      current mux position (drives the selector)
//   out_valid     result available
//   out_ready     downstream accepts result
//   out_row/col   position of the presented result
//   out_value     (acc >> OUT_SHIFT) saturated to 16 bits
//   frame_done    one-cycle pulse after the last element is accepted
// -----------------------------------------------------------------------------
module scan_integrator #(
    parameter int ROWS           = 7,
    parameter int COLS           = 7,
    parameter int COUNT_W        = 16,
    parameter int SETTLE_WINDOWS = 4,
    parameter int ACCUM_WINDOWS  = 16,
    parameter int OUT_SHIFT      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               count_valid,
    input  logic [COUNT_W-1:0] sel_count,
    input  logic [COUNT_W-1:0] center_count,
    output logic [2:0]         row,
    output logic [2:0]         col,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_row,
    output logic [2:0]         out_col,
    output logic [15:0]        out_value,
    output logic               frame_done
);

    // Accumulator wide enough for ACCUM_WINDOWS full-scale products.
    localparam int ACC_W = 2*COUNT_W + $clog2(ACCUM_WINDOWS);
    localparam int SET_W = (SETTLE_WINDOWS > 1) ? $clog2(SETTLE_WINDOWS) : 1;
    localparam int ACN_W = (ACCUM_WINDOWS > 1) ? $clog2(ACCUM_WINDOWS) : 1;
    // At least 17 bits so the saturation test always sees bit 16.
    localparam int SAT_W = (ACC_W > 16) ? ACC_W : 17;

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_WINDOWS - 1);
    localparam logic [ACN_W-1:0] ACCUM_LAST  = ACN_W'(ACCUM_WINDOWS - 1);
    localparam logic [2:0]       ROW_LAST    = 3'(ROWS - 1);
    localparam logic [2:0]       COL_LAST    = 3'(COLS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, EMIT} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         row_reg, row_next;
    logic [2:0]         col_reg, col_next;
    logic               out_valid_reg, out_valid_next;
    logic [2:0]         out_row_reg, out_row_next;
    logic [2:0]         out_col_reg, out_col_next;
    logic [15:0]        out_value_reg, out_value_next;
    logic               frame_done_reg, frame_done_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [ACN_W-1:0]   acc_cnt_reg, acc_cnt_next;

    logic [2*COUNT_W-1:0] product;
    logic [ACC_W-1:0]     acc_sum;
    logic [SAT_W-1:0]     shifted;
    logic [15:0]          sat_value;

    // Full-width unsigned product; operands widened so nothing is truncated.
    assign product   = {{COUNT_W{1'b0}}, sel_count} * {{COUNT_W{1'b0}}, center_count};
    assign acc_sum   = acc_reg + ACC_W'(product);
    assign shifted   = SAT_W'(acc_sum >> OUT_SHIFT);
    assign sat_value = (shifted > SAT_W'(16'hFFFF)) ? 16'hFFFF : shifted[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_row_reg    <= '0;
            out_col_reg    <= '0;
            out_value_reg  <= '0;
            frame_done_reg <= 1'b0;
            acc_reg        <= '0;
            settle_cnt_reg <= '0;
            acc_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            out_valid_reg  <= out_valid_next;
            out_row_reg    <= out_row_next;
            out_col_reg    <= out_col_next;
            out_value_reg  <= out_value_next;
            frame_done_reg <= frame_done_next;
            acc_reg        <= acc_next;
            settle_cnt_reg <= settle_cnt_next;
            acc_cnt_reg    <= acc_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        out_valid_next  = out_valid_reg;
        out_row_next    = out_row_reg;
        out_col_next    = out_col_reg;
        out_value_next  = out_value_reg;
        frame_done_next = 1'b0;
        acc_next        = acc_reg;
        settle_cnt_next = settle_cnt_reg;
        acc_cnt_next    = acc_cnt_reg;

        case (state_reg)
            IDLE: begin
                // Strobes here are ignored, including one in the enable cycle.
                if (enable) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                end
            end
            SETTLE: begin
                if (count_valid) begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_next   = ACCUM;
                        acc_next     = '0;
                        acc_cnt_next = '0;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (count_valid) begin
                    acc_next     = acc_sum;
                    acc_cnt_next = acc_cnt_reg + 1'b1;
                    // The final window's product is folded into the result directly.
                    if (acc_cnt_reg == ACCUM_LAST) begin
                        out_value_next = sat_value;
                        out_row_next   = row_reg;
                        out_col_next   = col_reg;
                        out_valid_next = 1'b1;
                        state_next     = EMIT;
                    end
                end
            end
            EMIT: begin
                // Result is held; windows arriving meanwhile are dropped.
                if (out_ready) begin
                    out_valid_next  = 1'b0;
                    settle_cnt_next = '0;
                    state_next      = enable ? SETTLE : IDLE;
                    if (col_reg == COL_LAST) begin
                        col_next = '0;
                        if (row_reg == ROW_LAST) begin
                            row_next        = '0;
                            frame_done_next = 1'b1;
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign row        = row_reg;
    assign col        = col_reg;
    assign out_valid  = out_valid_reg;
    assign out_row    = out_row_reg;
    assign out_col    = out_col_reg;
    assign out_value  = out_value_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_scan_integrator.sv
// -----------------------------------------------------------------------------
// tb_scan_integrator
//
// Directed bench for scan_integrator with default parameters (7x7, 4 settle
// windows, 16 accumulate windows, shift 8). Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_scan_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        count_valid;
    logic [15:0] sel_count;
    logic [15:0] center_count;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic [15:0] out_value;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int fd_cnt    = 0;

    scan_integrator dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .count_valid  (count_valid),
        .sel_count    (sel_count),
        .center_count (center_count),
        .row          (row),
        .col          (col),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_value    (out_value),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Cycle counts of asserted out_valid / frame_done.
    always @(posedge clk) begin
        if (out_valid === 1'b1)  valid_cnt <= valid_cnt + 1;
        if (frame_done === 1'b1) fd_cnt    <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobe; returns at the falling edge after it was sampled.
    task automatic pulse();
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap - 1) @(negedge clk);
            pulse();
        end
    endtask

    // Full element: 20 windows, result checked right after the last one.
    task automatic element(input logic [15:0] s, input logic [15:0] c, input int gap,
                           input int er, input int ec, input int ev);
        sel_count    = s;
        center_count = c;
        send(19, gap);
        check("early_valid", 32'(out_valid), 0);
        repeat (gap - 1) @(negedge clk);
        pulse();
        check("res_valid", 32'(out_valid), 1);
        check("res_row",   32'(out_row), 32'(er));
        check("res_col",   32'(out_col), 32'(ec));
        check("res_value", 32'(out_value), 32'(ev));
        check("mux_row",   32'(row), 32'(er));
        check("mux_col",   32'(col), 32'(ec));
        $display("result row=%0d col=%0d value=%0d", out_row, out_col, out_value);
    endtask

    // Expects out_ready high: one cycle later the handshake has taken effect.
    task automatic hs(input int nr, input int nc, input int fd);
        @(negedge clk);
        check("hs_valid", 32'(out_valid), 0);
        check("hs_row",   32'(row), 32'(nr));
        check("hs_col",   32'(col), 32'(nc));
        check("hs_fd",    32'(frame_done), 32'(fd));
    endtask

    initial begin
        int vbase;
        int fbase;
        int bad;
        int nr;
        int nc;

        rst = 1'b1; enable = 1'b0; count_valid = 1'b0;
        sel_count = '0; center_count = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_row",   32'(row), 0);
        check("rst_col",   32'(col), 0);
        check("rst_orow",  32'(out_row), 0);
        check("rst_ocol",  32'(out_col), 0);
        check("rst_value", 32'(out_value), 0);
        check("rst_fd",    32'(frame_done), 0);
        rst = 1'b0;

        // Strobes while disabled do nothing.
        sel_count = 16'd64; center_count = 16'd64;
        vbase = valid_cnt;
        send(25, 2);
        check("idle_no_valid", 32'(valid_cnt - vbase), 0);
        check("idle_row", 32'(row), 0);
        check("idle_col", 32'(col), 0);

        // Basic: 16*64*64 >> 8 = 256.
        enable = 1'b1;
        @(negedge clk);
        element(16'd64, 16'd64, 128, 0, 0, 256);
        hs(0, 1, 0);

        // Backpressure: 16*300*1000 >> 8 = 18750, held for 1000 cycles.
        out_ready = 1'b0;
        element(16'd300, 16'd1000, 4, 0, 1, 18750);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            count_valid = (i % 7 == 0);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_value !== 16'd18750 || out_row !== 3'd0 ||
                out_col !== 3'd1 || row !== 3'd0 || col !== 3'd1)
                bad++;
        end
        count_valid = 1'b0;
        check("bp_stable", 32'(bad), 0);
        out_ready = 1'b1;
        hs(0, 2, 0);

        // Saturation boundary: 1024*1024*16>>8 = 65536 -> 65535; 1024*1023 -> 65472.
        element(16'd1024, 16'd1024, 3, 0, 2, 65535);
        hs(0, 3, 0);
        element(16'd1024, 16'd1023, 3, 0, 3, 65472);
        hs(0, 4, 0);
        element(16'hFFFF, 16'hFFFF, 2, 0, 4, 65535);
        hs(0, 5, 0);
        element(16'd0, 16'd1234, 2, 0, 5, 0);
        hs(0, 6, 0);
        element(16'd100, 16'd50, 2, 0, 6, 312);
        hs(1, 0, 0);

        // Reset in ACCUM after 5 accumulate strobes.
        sel_count = 16'd64; center_count = 16'd64;
        send(9, 2);
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_row",   32'(row), 0);
        check("mrst_col",   32'(col), 0);
        check("mrst_value", 32'(out_value), 0);
        check("mrst_orow",  32'(out_row), 0);
        rst = 1'b0;
        vbase = valid_cnt;
        send(25, 2);
        check("mrst_no_valid", 32'(valid_cnt - vbase), 0);

        // Full frame: 16*100*50 >> 8 = 312 for every element.
        enable = 1'b1;
        @(negedge clk);
        fbase = fd_cnt;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                element(16'd100, 16'd50, 2, r, c, 312);
                nc = (c == 6) ? 0 : c + 1;
                nr = (c == 6) ? ((r == 6) ? 0 : r + 1) : r;
                hs(nr, nc, (r == 6 && c == 6) ? 1 : 0);
            end
        end
        @(negedge clk);
        check("fd_low_after", 32'(frame_done), 0);
        check("fd_once", 32'(fd_cnt - fbase), 1);
        check("frame_row", 32'(row), 0);
        check("frame_col", 32'(col), 0);

        // Drop enable mid-ACCUM: element completes, then IDLE.
        sel_count = 16'd64; center_count = 16'd64;
        send(7, 2);
        enable = 1'b0;
        @(negedge clk);
        send(12, 2);
        check("en_early_valid", 32'(out_valid), 0);
        @(negedge clk);
        pulse();
        check("en_valid", 32'(out_valid), 1);
        check("en_value", 32'(out_value), 256);
        check("en_orow",  32'(out_row), 0);
        check("en_ocol",  32'(out_col), 0);
        $display("result row=%0d col=%0d value=%0d", out_row, out_col, out_value);
        hs(0, 1, 0);
        vbase = valid_cnt;
        send(25, 2);
        check("en_no_valid", 32'(valid_cnt - vbase), 0);
        check("en_row", 32'(row), 0);
        check("en_col", 32'(col), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_integrator.md
# scan_integrator

Sequencer and correlator between the two diff samplers and the 7x7 display buffer. It steps the transducer-array mux through every element in raster order and waits a settle period after each mux change. It then multiplies and accumulates the per-window sel and center high counts, and hands one scaled 16-bit result per element downstream over a valid/ready handshake. Its row/col outputs drive the selector directly.

## Interface
Parameters:
- ROWS, 7, array rows (1..8)
- COLS, 7, array columns (1..8)
- COUNT_W, 16, width of each sampler count
- SETTLE_WINDOWS, 4, sample windows discarded after a mux change (>=1)
- ACCUM_WINDOWS, 16, sample windows integrated per element (>=1)
- OUT_SHIFT, 8, right shift applied to the accumulator before output

Ports:
- clk  in  1  single clock (pwm_clk domain). One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- enable  in  1  scan run request
- count_valid  in  1  one-cycle strobe: new sel_count/center_count window pair
- sel_count  in  COUNT_W  selected-element sampler count
- center_count  in  COUNT_W  center-element sampler count
- row  out  3  current mux row (to selector)
- col  out  3  current mux column (to selector)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_row  out  3  row of presented result
- out_col  out  3  column of presented result
- out_value  out  16  scaled, saturated result
- frame_done  out  1  one-cycle pulse on acceptance of element (ROWS-1, COLS-1)

## Operation
- ACC_W = 2*COUNT_W + clog2(ACCUM_WINDOWS). Products are unsigned and full width; there is no wrap inside acc.
- States: IDLE, SETTLE, ACCUM, EMIT.
- IDLE:
  - enable=1 -> SETTLE; settle_cnt=0.
  - count_valid is ignored.
- SETTLE:
  - Each count_valid increments settle_cnt.
  - count_valid while settle_cnt==SETTLE_WINDOWS-1 -> ACCUM; acc=0, acc_cnt=0.
- ACCUM:
  - Each count_valid: acc += sel_count*center_count; acc_cnt++.
  - On the count_valid with acc_cnt==ACCUM_WINDOWS-1, the new sum is used. out_value = min((acc+product)>>OUT_SHIFT, 16'hFFFF). out_row/out_col = row/col. out_valid=1. Next state -> EMIT.
- EMIT:
  - out_valid, out_value, out_row and out_col are held stable until out_ready=1.
  - count_valid is ignored; those windows are dropped.
- Handshake (out_valid & out_ready):
  - out_valid=0 next cycle.
  - row/col advance: col++; at col==COLS-1, col=0 and row++; at row==ROWS-1 as well, row=0 and frame_done=1 for one cycle.
  - Next state -> SETTLE if enable, else IDLE.
- enable is sampled only in IDLE and at handshake. Deasserting it mid-element completes the current element.
- rst in any state: next cycle all registers take their reset values, and any in-flight element is discarded.
- Reset values: state=IDLE, row=0, col=0, out_valid=0, out_row=0, out_col=0, out_value=0, frame_done=0, acc=0, settle_cnt=0, acc_cnt=0.

## Timing
- Final ACCUM count_valid at cycle t -> out_valid=1 and out_value valid at t+1.
- Handshake at cycle h:
  - row/col show the next element at h+1.
  - out_valid=0 at h+1.
  - frame_done=1 at h+1 only, for the last element.
- With out_ready tied high, each element takes SETTLE_WINDOWS+ACCUM_WINDOWS windows plus the handshake cycle. A count_valid arriving in the handshake cycle is dropped; the first settle window is the next strobe.
- A count_valid coincident with the IDLE->SETTLE transition cycle is not counted.
- Throughput: one result per element; there is no output buffering beyond the single held register.

## Test plan
- Reset: assert rst 2 cycles. All outputs are 0, state IDLE, and count_valid strobes with enable=0 produce no out_valid.
- Basic result: enable=1, sel_count=64, center_count=64, strobe every 128 cycles, out_ready=1, default params. The first out_valid appears after the 20th strobe with out_row=0, out_col=0, out_value=256 (16*4096>>8). row/col=0,1 follows the next cycle.
- Backpressure: hold out_ready=0 for 1000 cycles after out_valid. out_valid, out_value and row/col stay stable, and strobes are ignored. Raising out_ready gives a handshake, then advance to (0,1) with settle restarting.
- Full frame: constant counts, out_ready=1. There are 49 results in raster order (0,0)..(6,6). frame_done pulses exactly once, the cycle after the (6,6) handshake, and row/col return to (0,0).
- Saturation: sel_count=center_count=16'hFFFF, OUT_SHIFT=8 -> out_value=16'hFFFF. With sel_count=0 -> out_value=0.
- Mid-operation:
  - rst during ACCUM after 5 strobes: reset values, and no out_valid.
  - enable=0 during ACCUM: the element completes, the handshake occurs, then the block returns to IDLE with row/col advanced and no further results.
